axis_lutram_fifo: RTL and testbench
===================================

// Module: axis_lutram_fifo
// PURPOSE
//  AXI-Stream FIFO feeding/draining the axis_cpu datapath's simple-dual-port LUTRAM (sdp_lut_ram).
//  Owns write/read pointers, full/empty flags and occupancy count; drives the RAM's wr_en/wr_addr/rd_addr.
//  First-word-fall-through: async RAM read puts head word on m_tdata directly.
//  Sits between an upstream AXIS producer (e.g. packet ingress) and a downstream datapath consumer.
// PARAMETERS
//  DATA_WIDTH  32  width of s_tdata/m_tdata and RAM word
//  ADDR_WIDTH  4   RAM address bits; RAM DEPTH = 2**ADDR_WIDTH entries
// PORTS
//  clk       in   1             single clock; all state on posedge
//  rst_n     in   1             synchronous, active-low reset
//  s_tdata   in   DATA_WIDTH    upstream data
//  s_tvalid  in   1             upstream valid
//  s_tready  out  1             FIFO can accept (registered-state derived)
//  m_tdata   out  DATA_WIDTH    head-of-FIFO data
//  m_tvalid  out  1             head word present
//  m_tready  in   1             downstream accepts
//  count     out  ADDR_WIDTH+1  words held (incl. output reg when enabled)
// BEHAVIOUR
//  - push = s_tvalid & s_tready; pop = m_tvalid & m_tready. Both may occur same cycle.
//  - wr_ptr/rd_ptr: ADDR_WIDTH+1 bits; low bits address RAM, MSB is wrap bit; +1 mod 2**(ADDR_WIDTH+1).
//  - empty: wr_ptr == rd_ptr. full: MSBs differ, low bits equal.
//  - s_tready = ~full & rst_n; m_tvalid = ~empty; m_tdata = RAM[rd_ptr low bits] (undefined when empty).
//  - RAM write on push at wr_ptr; data visible on m_tdata cycle after push (latency 1).
//  - count updates: +1 push only, -1 pop only, unchanged both/neither; never exceeds DEPTH.
//  - full + pop: s_tready stays 0 that cycle (no fall-through push); rises next cycle.
//  - empty + push: no pop possible that cycle; m_tvalid rises next cycle.
//  - m_tdata/m_tvalid stable while m_tvalid & ~m_tready (AXIS rule).
//  - Reset (incl. mid-stream): pointers=0, count=0, m_tvalid=0, s_tready=0 during reset, 1 cycle after
//    release; in-flight words discarded; RAM contents not cleared.
// CONFIGURATION
//  Macro AXIS_LUTRAM_FIFO_OREG_EN:
//  - Defined: registered output stage after RAM; m_tdata/m_tvalid from flops (timing break).
//    Out reg loads RAM head when (out reg empty | pop) & RAM non-empty. Latency push->m_tvalid = 2.
//    Capacity DEPTH+1; count includes out reg (max DEPTH+1). Out reg valid cleared on reset.
//  - Undefined: combinational FWFT as above; latency 1; capacity DEPTH.
// STRUCTURE
//  - Shared package axis_cpu_pkg: DEPTH/PTR_WIDTH derivation constants, AXIS beat typedef (data+valid).
//  - Sub-module fifo_ptr: wrap-bit pointer counter (inc enable, sync reset), instanced for wr and rd.
//  - RAM: one sdp_lut_ram instance (DATA_WIDTH, ADDR_WIDTH passed through).
// TESTING (DATA_WIDTH=32, ADDR_WIDTH=4 unless noted; run with and without OREG_EN)
//  1 Push 0xA0..0xAF (16 words), m_tready=0 -> s_tready=0 after 16th, count=16 (17 w/ OREG after 17th).
//  2 Drain with m_tready=1 -> m_tdata 0xA0..0xAF in order, m_tvalid falls after last, count=0.
//  3 Empty FIFO, push 0x55 at cycle t -> m_tvalid=1, m_tdata=0x55 at t+1 (t+2 with OREG).
//  4 Full, s_tvalid=1 & m_tready=1 one cycle -> 1 pop, 0 push, count=15; next cycle push accepted.
//  5 Half full (8), continuous push+pop 40 cycles -> count stays 8, pointers wrap, order preserved.
//  6 Reset asserted with count=5 -> next cycle count=0, m_tvalid=0; s_tready=1 one cycle after release.

Source files
------------

// File: rtl/axis_cpu_pkg.sv
// Shared constants and types for the axis_cpu datapath FIFOs.
package axis_cpu_pkg;

  localparam int unsigned AxisDataWidth = 32;
  localparam int unsigned FifoAddrWidth = 4;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // One extra pointer bit distinguishes full from empty.
  function automatic int unsigned fifo_ptr_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

  typedef struct packed {
    logic [AxisDataWidth-1:0] data;
    logic                     valid;
  } axis_beat_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit FIFO pointer: increments modulo 2**Width on inc_i, synchronous clear.
module fifo_ptr #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] ptr_o
);

  logic [Width-1:0] ptr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (inc_i) begin
      ptr_q <= ptr_q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sdp_lut_ram.sv
// Simple-dual-port LUTRAM: synchronous write, asynchronous read, no reset.
module sdp_lut_ram
  import axis_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned Depth = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_lutram_fifo.sv
// AXI-Stream FWFT FIFO over an SDP LUTRAM. Define AXIS_LUTRAM_FIFO_OREG_EN to add a
// registered output stage (capacity DEPTH+1, push->m_tvalid latency 2).
module axis_lutram_fifo
  import axis_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned PtrWidth = fifo_ptr_width(ADDR_WIDTH);

  logic [PtrWidth-1:0]   wr_ptr;
  logic [PtrWidth-1:0]   rd_ptr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  ram_empty;
  logic                  ram_full;
  logic                  push;
  logic                  pop;
  logic                  ram_rd;

  assign ram_empty = (wr_ptr == rd_ptr);
  assign ram_full  = (wr_ptr[PtrWidth-1] != rd_ptr[PtrWidth-1]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign s_tready = ~ram_full & rst_n;
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;

`ifdef AXIS_LUTRAM_FIFO_OREG_EN
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  // Refill the output register whenever it is empty or being drained.
  assign ram_rd = (~out_valid_q | pop) & ~ram_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (ram_rd) begin
      out_valid_q <= 1'b1;
    end else if (pop) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_rd) begin
      out_data_q <= ram_rd_data;
    end
  end

  assign m_tvalid = out_valid_q;
  assign m_tdata  = out_data_q;
`else
  assign ram_rd   = pop;
  assign m_tvalid = ~ram_empty;
  assign m_tdata  = ram_rd_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end else if (pop && !push) begin
      count_q <= count_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
  end

  assign count = count_q;

  fifo_ptr #(
    .Width (PtrWidth)
  ) u_wr_ptr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (push),
    .ptr_o  (wr_ptr)
  );

  fifo_ptr #(
    .Width (PtrWidth)
  ) u_rd_ptr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (ram_rd),
    .ptr_o  (rd_ptr)
  );

  sdp_lut_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data_i (s_tdata),
    .rd_addr_i (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data_o (ram_rd_data)
  );

endmodule

// File: tb/tb_axis_lutram_fifo.sv
// Self-checking bench for axis_lutram_fifo; honours AXIS_LUTRAM_FIFO_OREG_EN.
module tb_axis_lutram_fifo;
  import axis_cpu_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int          Depth = fifo_depth(AW);
`ifdef AXIS_LUTRAM_FIFO_OREG_EN
  localparam bit Oreg = 1'b1;
`else
  localparam bit Oreg = 1'b0;
`endif
  localparam int Lat = Oreg ? 2 : 1;
  localparam int Cap = Depth + (Oreg ? 1 : 0);

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [DW-1:0] s_tdata  = '0;
  logic          s_tvalid = 1'b0;
  logic          m_tready = 1'b0;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  // Reference model: words in order with the cycle each was accepted.
  logic [DW-1:0] mq[$];
  longint        tq[$];
  longint        cyc = 0;

  typedef struct {
    bit          r;
    axis_beat_t  s;
    bit          mr;
    bit          e_sr;
    bit          e_mv;
    int          e_cnt;
    logic [31:0] e_d;
  } vec_t;

  vec_t tv;
  bit   tv_en = 1'b0;
  vec_t vecs[10];

  axis_lutram_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit mod_mv();
    return (mq.size() > 0) && (cyc >= tq[0] + Lat);
  endfunction

  function automatic bit mod_sr(input bit r);
    int ram_words;
    ram_words = mq.size() - ((Oreg && mod_mv()) ? 1 : 0);
    return r && (ram_words < Depth);
  endfunction

  task automatic step(input bit r, input bit sv, input logic [DW-1:0] sd, input bit mr);
    bit esr, emv, push, pop;
    rst_n = r; s_tvalid = sv; s_tdata = sd; m_tready = mr;
    @(negedge clk);
    esr = mod_sr(r);
    emv = mod_mv();
    chk("s_tready", s_tready, esr);
    chk("m_tvalid", m_tvalid, emv);
    chk("count", count, mq.size());
    if (emv) chk("m_tdata", m_tdata, mq[0]);
    if (tv_en) begin
      chk("vec_s_tready", s_tready, tv.e_sr);
      chk("vec_m_tvalid", m_tvalid, tv.e_mv);
      chk("vec_count", count, tv.e_cnt);
      if (tv.e_mv) chk("vec_m_tdata", m_tdata, tv.e_d);
    end
    push = sv && esr;
    pop  = emv && mr;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      tq.delete();
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        void'(tq.pop_front());
      end
      if (push) begin
        mq.push_back(sd);
        tq.push_back(cyc);
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    vecs[0] = '{0, '{32'h11, 1'b1}, 0, 0, 0, 0, 32'h0};
    vecs[1] = '{1, '{32'h55, 1'b1}, 1, 1, 0, 0, 32'h0};
    vecs[2] = '{1, '{32'h00, 1'b0}, 1, 1, !Oreg, 1, 32'h55};
    vecs[3] = '{1, '{32'h00, 1'b0}, 0, 1, Oreg, Oreg ? 1 : 0, 32'h55};
    vecs[4] = '{1, '{32'h00, 1'b0}, 1, 1, Oreg, Oreg ? 1 : 0, 32'h55};
    vecs[5] = '{1, '{32'h66, 1'b1}, 0, 1, 0, 0, 32'h0};
    vecs[6] = '{1, '{32'h77, 1'b1}, 0, 1, !Oreg, 1, 32'h66};
    vecs[7] = '{1, '{32'h00, 1'b0}, 0, 1, 1, 2, 32'h66};
    vecs[8] = '{0, '{32'h00, 1'b0}, 0, 0, 1, 2, 32'h66};
    vecs[9] = '{1, '{32'h00, 1'b0}, 0, 1, 0, 0, 32'h0};

    step(0, 0, '0, 0);
    step(0, 0, '0, 0);

    for (int i = 0; i < 10; i++) begin
      tv    = vecs[i];
      tv_en = 1'b1;
      step(tv.r, tv.s.valid, tv.s.data, tv.mr);
      tv_en = 1'b0;
    end

    // Fill to capacity with the consumer stalled, then one rejected beat.
    for (int i = 0; i < Cap; i++) step(1, 1, 32'hA0 + i, 0);
    step(1, 1, 32'hEE, 0);
    chk("fill_count", count, Cap);
    chk("fill_s_tready", s_tready, 0);

    // Drain; order is checked against the model each cycle.
    for (int i = 0; i < Cap + 3; i++) step(1, 0, '0, 1);
    chk("drain_count", count, 0);
    chk("drain_m_tvalid", m_tvalid, 0);

    // Full with simultaneous push and pop: only the pop happens.
    for (int i = 0; i < Cap; i++) step(1, 1, 32'hC0 + i, 0);
    step(1, 1, 32'hFF, 1);
    chk("fullpop_count", count, Cap - 1);
    chk("fullpop_s_tready", s_tready, 1);
    step(1, 1, 32'hD0, 0);
    chk("refill_count", count, Cap);

    // Half full, then steady push+pop across pointer wrap.
    for (int i = 0; i < Cap - 8; i++) step(1, 0, '0, 1);
    chk("half_count", count, 8);
    for (int i = 0; i < 40; i++) step(1, 1, 32'h100 + i, 1);
    chk("steady_count", count, 8);

    // Mid-stream reset at count 5.
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1);
    chk("pre_rst_count", count, 5);
    step(0, 0, '0, 0);
    chk("rst_count", count, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    step(1, 0, '0, 0);
    chk("release_s_tready", s_tready, 1);

    // Randomised phases alternating between filling and draining bias.
    for (int i = 0; i < 3000; i++) begin
      bit fillp;
      fillp = ((i / 300) % 2) == 0;
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 99) < (fillp ? 80 : 30),
           $urandom,
           $urandom_range(0, 99) < (fillp ? 30 : 80));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
